// File: rtl/pcie_pattern_gen_if.sv
// Valid/ready word stream from the pattern generator to the serializer,
// plus the generator's run control and status.
interface pcie_pattern_gen_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic                  enable;
  logic [1:0]            mode;
  logic                  ready;
  logic [DATA_WIDTH-1:0] DATA;
  logic                  Valid;
  logic                  is_comma;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  burst_cnt;

  modport master (
    input  enable, mode, ready,
    output DATA, Valid, is_comma, busy, burst_cnt
  );

  modport slave (
    output enable, mode, ready,
    input  DATA, Valid, is_comma, busy, burst_cnt
  );
endinterface

// File: rtl/pcie_pattern_gen.sv
// Framed burst source: COMMA_LEN commas, BURST_LEN payload words (INC/LFSR/FIXED),
// then GAP_LEN idle cycles. All outputs are registered; backpressure stalls the stream.
module pcie_pattern_gen #(
  parameter int                    DATA_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0] COMMA_SYMBOL  = DATA_WIDTH'(8'hBC),
  parameter int                    COMMA_LEN     = 1,
  parameter int                    BURST_LEN     = 8,
  parameter int                    GAP_LEN       = 2,
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS     = DATA_WIDTH'(8'hB8),
  parameter logic [DATA_WIDTH-1:0] LFSR_SEED     = DATA_WIDTH'(8'h01),
  parameter logic [DATA_WIDTH-1:0] FIXED_PATTERN = DATA_WIDTH'(8'h25),
  parameter int                    CNT_WIDTH     = 16
) (
  input logic               CLK,
  input logic               RESET,
  pcie_pattern_gen_if.master bus
);

  localparam int WC_MAX = (COMMA_LEN > BURST_LEN) ? COMMA_LEN : BURST_LEN;
  localparam int WC_W   = $clog2(WC_MAX + 1);
  localparam int GC_W   = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [1:0] M_LFSR  = 2'd1;
  localparam logic [1:0] M_FIXED = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_COMMA, S_BURST, S_GAP} state_e;

  state_e                state_q, state_d;
  logic [WC_W-1:0]       wcnt_q, wcnt_d;
  logic [GC_W-1:0]       gcnt_q, gcnt_d;
  logic [DATA_WIDTH-1:0] lfsr_q, lfsr_d, lfsr_next;
  logic [1:0]            mode_q, mode_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  comma_q, comma_d;
  logic                  busy_q, busy_d;
  logic [CNT_WIDTH-1:0]  bcnt_q, bcnt_d;
  logic                  accept;
  logic                  start_burst;
  logic                  go_idle;

  function automatic logic [DATA_WIDTH-1:0] lfsr_step(input logic [DATA_WIDTH-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

  // Payload word at position idx of the burst; the LFSR word is supplied already advanced.
  function automatic logic [DATA_WIDTH-1:0] payload(input logic [1:0]            m,
                                                    input logic [WC_W-1:0]       idx,
                                                    input logic [DATA_WIDTH-1:0] l);
    case (m)
      M_LFSR:  return l;
      M_FIXED: return idx[0] ? ~FIXED_PATTERN : FIXED_PATTERN;
      default: return DATA_WIDTH'(idx);
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    gcnt_d      = gcnt_q;
    lfsr_d      = lfsr_q;
    lfsr_next   = lfsr_q;
    mode_d      = mode_q;
    data_d      = data_q;
    valid_d     = valid_q;
    comma_d     = comma_q;
    busy_d      = busy_q;
    bcnt_d      = bcnt_q;
    accept      = valid_q && bus.ready;
    start_burst = 1'b0;
    go_idle     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.enable) start_burst = 1'b1;
      end
      S_COMMA: begin
        if (accept) begin
          if (wcnt_q == WC_W'(COMMA_LEN - 1)) begin
            state_d = S_BURST;
            wcnt_d  = '0;
            data_d  = payload(mode_q, '0, lfsr_q);
            comma_d = 1'b0;
          end else begin
            wcnt_d = wcnt_q + WC_W'(1);
          end
        end
      end
      S_BURST: begin
        if (accept) begin
          lfsr_next = (mode_q == M_LFSR) ? lfsr_step(lfsr_q) : lfsr_q;
          lfsr_d    = lfsr_next;
          if (wcnt_q == WC_W'(BURST_LEN - 1)) begin
            bcnt_d = bcnt_q + CNT_WIDTH'(1);
            if (GAP_LEN != 0) begin
              state_d = S_GAP;
              gcnt_d  = '0;
              valid_d = 1'b0;
              data_d  = '0;
            end else if (bus.enable) begin
              start_burst = 1'b1;
            end else begin
              go_idle = 1'b1;
            end
          end else begin
            wcnt_d = wcnt_q + WC_W'(1);
            data_d = payload(mode_q, wcnt_q + WC_W'(1), lfsr_next);
          end
        end
      end
      S_GAP: begin
        // The gap is a fixed number of cycles; ready has no effect here.
        if (gcnt_q == GC_W'(GAP_LEN - 1)) begin
          if (bus.enable) start_burst = 1'b1;
          else            go_idle     = 1'b1;
        end else begin
          gcnt_d = gcnt_q + GC_W'(1);
        end
      end
      default: go_idle = 1'b1;
    endcase

    // Mode is only sampled on entry to the comma phase.
    if (start_burst) begin
      state_d = S_COMMA;
      mode_d  = bus.mode;
      wcnt_d  = '0;
      data_d  = COMMA_SYMBOL;
      valid_d = 1'b1;
      comma_d = 1'b1;
      busy_d  = 1'b1;
    end
    if (go_idle) begin
      state_d = S_IDLE;
      data_d  = '0;
      valid_d = 1'b0;
      comma_d = 1'b0;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      gcnt_q  <= '0;
      lfsr_q  <= LFSR_SEED;
      mode_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      comma_q <= 1'b0;
      busy_q  <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      gcnt_q  <= gcnt_d;
      lfsr_q  <= lfsr_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      comma_q <= comma_d;
      busy_q  <= busy_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign bus.DATA      = data_q;
  assign bus.Valid     = valid_q;
  assign bus.is_comma  = comma_q;
  assign bus.busy      = busy_q;
  assign bus.burst_cnt = bcnt_q;

endmodule

// File: doc/pcie_pattern_gen.md
Name: pcie_pattern_gen

Overview:
Synthesizable, parametrised stimulus source for the parallel-to-serial-to-parallel PCIe datapath. It replaces fixed hand-timed DATA sequences with framed bursts. Each burst is COMMA_LEN comma symbols, then BURST_LEN payload words, then GAP_LEN idle cycles. Payload is selectable per burst: incrementing, LFSR or fixed-alternating. Output uses a valid/ready handshake so the serializer can apply backpressure.

Parameters:
DATA_WIDTH, 8, width of DATA and all pattern words
COMMA_SYMBOL, 8'hBC, comma/alignment word (DATA_WIDTH bits)
COMMA_LEN, 1, comma words per burst (>=1)
BURST_LEN, 8, payload words per burst (>=1)
GAP_LEN, 2, idle cycles after each burst (>=0; 0 = back-to-back)
LFSR_TAPS, 8'hB8, Galois LFSR tap mask
LFSR_SEED, 8'h01, LFSR reset value (nonzero)
FIXED_PATTERN, 8'h25, fixed-mode word (alternates with its complement)
CNT_WIDTH, 16, width of burst_cnt

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous, active-low reset
enable  input  1  start/continue bursts while high
mode  input  2  payload mode: 0 INC, 1 LFSR, 2 FIXED, 3 = INC
ready  input  1  downstream accepts word when Valid&&ready
DATA  output  DATA_WIDTH  current word
Valid  output  1  DATA is valid
is_comma  output  1  current word is COMMA_SYMBOL
busy  output  1  FSM not in IDLE
burst_cnt  output  CNT_WIDTH  completed bursts, wraps to 0

Behaviour:
- Reset (RESET=0, asynchronous): DATA=0, Valid=0, is_comma=0, busy=0, burst_cnt=0. State = IDLE, LFSR = LFSR_SEED, counters = 0. A reset mid-burst aborts immediately; no partial completion.
- All outputs are registered. "Accept" means Valid&&ready at a rising edge.
- FSM states: IDLE, COMMA, BURST, GAP.
- IDLE: Valid=0. When enable is 1 at an edge, the FSM goes to COMMA and latches mode. The first comma is visible the cycle after that edge (1-cycle latency).
- COMMA: DATA=COMMA_SYMBOL, Valid=1, is_comma=1. After COMMA_LEN accepts, go to BURST.
- BURST: Valid=1, is_comma=0. Advance to the next word on each accept. On the BURST_LEN-th accept, burst_cnt+1 and go to GAP, or to COMMA directly if GAP_LEN=0 and enable=1.
- GAP: Valid=0, DATA=0. Counts GAP_LEN clock cycles; ready is ignored. At the end, go to COMMA if enable=1 (mode re-latched), else IDLE.
- Backpressure: while Valid=1 and ready=0, DATA, Valid and is_comma hold stable. Word counters and LFSR stall.
- INC mode: first payload word = 0; +1 per accept, modulo 2^DATA_WIDTH. Restarts at 0 each burst.
- LFSR mode:
  - DATA = LFSR state.
  - On accept: next = (s>>1) ^ (s[0] ? LFSR_TAPS : 0).
  - State persists across bursts; it is only reloaded by reset.
- FIXED mode: words alternate FIXED_PATTERN, ~FIXED_PATTERN, starting with FIXED_PATTERN each burst.
- mode changes mid-burst are ignored until the next COMMA entry.
- enable deasserted during COMMA or BURST: the current burst completes, including GAP, then the FSM goes to IDLE. It is never truncated.
- enable deasserted then reasserted within GAP: the next burst starts normally.
- burst_cnt wraps from all-ones to 0 without a flag.
- busy=1 in COMMA, BURST and GAP.

Test Plan:
- Reset, enable=1, mode=0, ready=1 -> DATA sequence BC,00,01,...,07 with Valid=1 and is_comma only on BC. Then 2 cycles Valid=0, then BC again. burst_cnt=1 after the 07 accept.
- mode=1, ready=1 -> payload 01,B8,5C,2E,17,B3,... Second burst continues the LFSR sequence, not restarting at 01.
- mode=2, ready toggling 1,0,0,1 during burst -> 25,DA,25,DA,... DATA held stable while ready=0. Total accepts = 8 per burst.
- enable dropped on the 3rd payload word -> burst completes to word 07, 2 gap cycles, then IDLE with busy=0 and Valid=0.
- RESET asserted mid-BURST (asynchronously, between edges) -> outputs 0 immediately. After release with enable=1, the restart is BC,00 and the LFSR is back at 01.
- Parameters BURST_LEN=2, GAP_LEN=0, CNT_WIDTH=2 -> back-to-back BC,00,01,BC,... burst_cnt goes 1,2,3,0.
